data_memory: RTL and testbench



---
 rtl/mips_pkg.sv | 17 +
 rtl/dmem_lane_align.sv | 55 +++++
 rtl/data_memory.sv | 75 +++++++
 tb/tb_data_memory.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared constants for the MIPS datapath. Holds the access-size encodings
// used by the data memory for loads and stores.
// ---------------------------------------------------------------------------
package mips_pkg;

    // Access size presented on data_memory.sel
    localparam logic [1:0] SEL_WORD = 2'b00;
    localparam logic [1:0] SEL_HALF = 2'b01;
    localparam logic [1:0] SEL_BYTE = 2'b10;
    localparam logic [1:0] SEL_RSVD = 2'b11;

    // Number of byte lanes in one memory word
    localparam int NUM_LANES = 4;

endpackage : mips_pkg

// File: rtl/dmem_lane_align.sv
// ---------------------------------------------------------------------------
// dmem_lane_align
// Purely combinational lane steering for the data memory.
//   Store path: lane write-enables plus the store data replicated so that
//               every lane sees the byte/halfword it may need.
//   Load path : picks the addressed halfword/byte out of the read word and
//               zero-extends it (sign extension happens downstream).
// Ports:
//   sel_i[1:0]        access size (SEL_WORD/HALF/BYTE/RSVD)
//   byte_addr_i[1:0]  byte offset within the word
//   wdata_i[31:0]     right-justified store data
//   rword_i[31:0]     word currently held at the addressed location
//   lane_we_o[3:0]    per-lane write enable (lane k = bits 8k+7:8k)
//   wword_o[31:0]     store data aligned to the lanes
//   rdata_o[31:0]     right-justified, zero-extended load data
// ---------------------------------------------------------------------------
module dmem_lane_align
    import mips_pkg::*;
(
    input  logic [1:0]  sel_i,
    input  logic [1:0]  byte_addr_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  lane_we_o,
    output logic [31:0] wword_o,
    output logic [31:0] rdata_o
);

    always_comb begin
        lane_we_o = '0;
        wword_o   = wdata_i;
        rdata_o   = rword_i;
        case (sel_i)
            SEL_WORD: begin
                // byte_addr is ignored: word accesses are treated as aligned
                lane_we_o = 4'b1111;
            end
            SEL_HALF: begin
                // only byte_addr[1] picks the half; byte_addr[0] is ignored
                lane_we_o = byte_addr_i[1] ? 4'b1100 : 4'b0011;
                wword_o   = {2{wdata_i[15:0]}};
                rdata_o   = {16'h0000, (byte_addr_i[1] ? rword_i[31:16] : rword_i[15:0])};
            end
            SEL_BYTE: begin
                lane_we_o = 4'b0001 << byte_addr_i;
                wword_o   = {4{wdata_i[7:0]}};
                rdata_o   = {24'h000000, rword_i[{byte_addr_i, 3'b000} +: 8]};
            end
            default: begin
                // reserved size: no store, load returns the full word
            end
        endcase
    end

endmodule : dmem_lane_align

// File: rtl/data_memory.sv
// ---------------------------------------------------------------------------
// data_memory
// Word-organised, little-endian data memory for the single-cycle MIPS MEM
// stage. Writes are per-lane on rising clk; reads are asynchronous.
// Synchronous reset clears every word and takes priority over a store.
// Ports:
//   clk               rising-edge clock for writes and reset
//   rst               synchronous active-high clear of all words
//   MemWrite          store enable
//   sel[1:0]          access size: 00 word, 01 half, 10 byte, 11 reserved
//   Address[29:0]     word address (byte address bits 31:2); wraps at DEPTH
//   byte_addr[1:0]    byte offset within the word
//   Write_data[31:0]  right-justified store data
//   Read_data[31:0]   right-justified, zero-extended load data
// ---------------------------------------------------------------------------
module data_memory
    import mips_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemWrite,
    input  logic [1:0]  sel,
    input  logic [29:0] Address,
    input  logic [1:0]  byte_addr,
    input  logic [31:0] Write_data,
    output logic [31:0] Read_data
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] idx;
    logic [31:0]   rword;
    logic [31:0]   wword;
    logic [3:0]    lane_we;
    logic [31:0]   word_d;

    // Upper address bits do not select anything: addresses wrap.
    assign idx = Address[AW-1:0];

    logic unused_addr;
    assign unused_addr = ^Address[29:AW];

    assign rword = mem_q[idx];

    dmem_lane_align u_align (
        .sel_i       (sel),
        .byte_addr_i (byte_addr),
        .wdata_i     (Write_data),
        .rword_i     (rword),
        .lane_we_o   (lane_we),
        .wword_o     (wword),
        .rdata_o     (Read_data)
    );

    // Merge enabled lanes of the store into the current word so the array
    // is written one whole word at a time.
    always_comb begin
        word_d = rword;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (lane_we[k]) word_d[8*k +: 8] = wword[8*k +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (MemWrite) begin
            mem_q[idx] <= word_d;
        end
    end

endmodule : data_memory

// File: tb/tb_data_memory.sv
module tb_data_memory;
    import mips_pkg::*;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemWrite;
    logic [1:0]  sel;
    logic [29:0] Address;
    logic [1:0]  byte_addr;
    logic [31:0] Write_data;
    logic [31:0] Read_data;

    int tests  = 0;
    int failed = 0;

    // Scoreboard: expected read value pushed when a read is driven,
    // popped when Read_data is sampled.
    logic [31:0] exp_q [$];

    data_memory #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .MemWrite   (MemWrite),
        .sel        (sel),
        .Address    (Address),
        .byte_addr  (byte_addr),
        .Write_data (Write_data),
        .Read_data  (Read_data)
    );

    always #5 clk = ~clk;

    // Drive a store, let it land on the next rising edge.
    task automatic st(input int a, input logic [1:0] s, input logic [1:0] b, input logic [31:0] d);
        @(negedge clk);
        MemWrite = 1'b1; Address = 30'(a); sel = s; byte_addr = b; Write_data = d;
        @(posedge clk);
        #1 MemWrite = 1'b0;
    endtask

    // Drive a read and record what it must return; caller compares.
    task automatic rd(input int a, input logic [1:0] s, input logic [1:0] b, input logic [31:0] e);
        @(negedge clk);
        MemWrite = 1'b0; Address = 30'(a); sel = s; byte_addr = b;
        exp_q.push_back(e);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        int ra [3] = '{0, 127, 255};
        logic [31:0] e;
        rst = 1'b1; MemWrite = 1'b0; sel = SEL_WORD; Address = '0; byte_addr = '0; Write_data = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rd(ra[i], SEL_WORD, 2'b00, 32'h0);
            e = exp_q.pop_front(); tests++;
            if (Read_data !== e) begin
                failed++; $display("FAIL reset word %0d: got %h want %h", ra[i], Read_data, e);
            end
        end
    endtask

    task automatic test_word();
        int          ra [2] = '{127, 126};
        logic [31:0] re [2] = '{32'h0000FAFA, 32'h0};
        logic [31:0] e;
        st(127, SEL_WORD, 2'b00, 32'h0000FAFA);
        for (int i = 0; i < 2; i++) begin
            rd(ra[i], SEL_WORD, 2'b00, re[i]);
            e = exp_q.pop_front(); tests++;
            if (Read_data !== e) begin
                failed++; $display("FAIL word store rd %0d: got %h want %h", ra[i], Read_data, e);
            end
        end
    endtask

    task automatic test_half();
        logic [1:0]  rs [4] = '{SEL_WORD, SEL_HALF, SEL_HALF, SEL_HALF};
        logic [1:0]  rb [4] = '{2'b00, 2'b10, 2'b00, 2'b11};
        logic [31:0] re [4] = '{32'hABCD0000, 32'h0000ABCD, 32'h0, 32'h0000ABCD};
        logic [31:0] e;
        // upper store bits must be ignored
        st(125, SEL_HALF, 2'b10, 32'h5555ABCD);
        for (int i = 0; i < 4; i++) begin
            rd(125, rs[i], rb[i], re[i]);
            e = exp_q.pop_front(); tests++;
            if (Read_data !== e) begin
                failed++; $display("FAIL half sel=%0d ba=%0d: got %h want %h", rs[i], rb[i], Read_data, e);
            end
        end
    endtask

    task automatic test_byte();
        logic [1:0]  rs [5] = '{SEL_WORD, SEL_BYTE, SEL_BYTE, SEL_BYTE, SEL_HALF};
        logic [1:0]  rb [5] = '{2'b00, 2'b01, 2'b11, 2'b00, 2'b00};
        logic [31:0] re [5] = '{32'hAD00BF00, 32'h000000BF, 32'h000000AD, 32'h0, 32'h0000BF00};
        logic [31:0] e;
        st(124, SEL_BYTE, 2'b01, 32'h123456BF);
        st(124, SEL_BYTE, 2'b11, 32'hFFFFFFAD);
        for (int i = 0; i < 5; i++) begin
            rd(124, rs[i], rb[i], re[i]);
            e = exp_q.pop_front(); tests++;
            if (Read_data !== e) begin
                failed++; $display("FAIL byte sel=%0d ba=%0d: got %h want %h", rs[i], rb[i], Read_data, e);
            end
        end
    endtask

    task automatic test_rsvd_and_aligned();
        int          ra [3] = '{123, 126, 124};
        logic [1:0]  rs [3] = '{SEL_WORD, SEL_WORD, SEL_RSVD};
        logic [31:0] re [3] = '{32'h0, 32'h0000BABA, 32'hAD00BF00};
        logic [31:0] e;
        st(123, SEL_RSVD, 2'b00, 32'h0000FABC);
        st(126, SEL_WORD, 2'b11, 32'h0000BABA);
        for (int i = 0; i < 3; i++) begin
            rd(ra[i], rs[i], 2'b11, re[i]);
            e = exp_q.pop_front(); tests++;
            if (Read_data !== e) begin
                failed++; $display("FAIL rsvd/aligned word %0d: got %h want %h", ra[i], Read_data, e);
            end
        end
    endtask

    task automatic test_write_timing();
        logic [31:0] e;
        // During the write cycle the old contents must still be visible.
        @(negedge clk);
        MemWrite = 1'b1; Address = 30'd10; sel = SEL_WORD; byte_addr = 2'b00; Write_data = 32'h11223344;
        exp_q.push_back(32'h0);
        #1;
        e = exp_q.pop_front(); tests++;
        if (Read_data !== e) begin
            failed++; $display("FAIL read during write: got %h want %h", Read_data, e);
        end
        @(posedge clk);
        exp_q.push_back(32'h11223344);
        #1 MemWrite = 1'b0;
        e = exp_q.pop_front(); tests++;
        if (Read_data !== e) begin
            failed++; $display("FAIL read after write: got %h want %h", Read_data, e);
        end
        // halfword store leaves the other half untouched
        st(10, SEL_HALF, 2'b01, 32'hFFFF1234);
        rd(10, SEL_WORD, 2'b00, 32'h11221234);
        e = exp_q.pop_front(); tests++;
        if (Read_data !== e) begin
            failed++; $display("FAIL half merge: got %h want %h", Read_data, e);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] e;
        st(DEPTH + 5, SEL_WORD, 2'b00, 32'hCAFEF00D);
        rd(5, SEL_WORD, 2'b00, 32'hCAFEF00D);
        e = exp_q.pop_front(); tests++;
        if (Read_data !== e) begin
            failed++; $display("FAIL wrap: got %h want %h", Read_data, e);
        end
    endtask

    task automatic test_reset_priority();
        int          ra [3] = '{127, 125, 5};
        logic [31:0] e;
        rd(127, SEL_WORD, 2'b00, 32'h0000FAFA);
        e = exp_q.pop_front(); tests++;
        if (Read_data !== e) begin
            failed++; $display("FAIL pre-reset word 127: got %h want %h", Read_data, e);
        end
        @(negedge clk);
        rst = 1'b1; MemWrite = 1'b1; Address = 30'd127; sel = SEL_WORD; byte_addr = 2'b00;
        Write_data = 32'h00001234;
        @(posedge clk);
        #1 rst = 1'b0; MemWrite = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rd(ra[i], SEL_WORD, 2'b00, 32'h0);
            e = exp_q.pop_front(); tests++;
            if (Read_data !== e) begin
                failed++; $display("FAIL reset+write word %0d: got %h want %h", ra[i], Read_data, e);
            end
        end
    endtask

    // Random stores on consecutive cycles into a small window, checked
    // against a byte-granular model.
    task automatic test_back_to_back();
        logic [7:0]  mb [8][4];
        logic [31:0] w, e, d;
        logic [1:0]  s, b;
        int          a;
        do_reset();
        for (int i = 0; i < 8; i++) for (int k = 0; k < 4; k++) mb[i][k] = 8'h00;
        for (int n = 0; n < 40; n++) begin
            a = $urandom_range(0, 7);
            s = 2'($urandom_range(0, 3));
            b = 2'($urandom_range(0, 3));
            d = $urandom;
            st(a, s, b, d);
            case (s)
                2'b00: for (int k = 0; k < 4; k++) mb[a][k] = d[8*k +: 8];
                2'b01: begin
                    mb[a][b[1] ? 2 : 0] = d[7:0];
                    mb[a][b[1] ? 3 : 1] = d[15:8];
                end
                2'b10: mb[a][b] = d[7:0];
                default: ;
            endcase
        end
        for (int n = 0; n < 24; n++) begin
            a = n % 8;
            s = 2'($urandom_range(0, 3));
            b = 2'($urandom_range(0, 3));
            w = {mb[a][3], mb[a][2], mb[a][1], mb[a][0]};
            case (s)
                2'b01:   e = b[1] ? {16'h0, w[31:16]} : {16'h0, w[15:0]};
                2'b10:   e = {24'h0, mb[a][b]};
                default: e = w;
            endcase
            rd(a, s, b, e);
            e = exp_q.pop_front(); tests++;
            if (Read_data !== e) begin
                failed++; $display("FAIL b2b word %0d sel=%0d ba=%0d: got %h want %h", a, s, b, Read_data, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_half();
        test_byte();
        test_rsvd_and_aligned();
        test_write_timing();
        test_wrap();
        test_reset_priority();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule : tb_data_memory
